// File: rtl/instr_encoder_if.sv
// Field-set input bus, encoded-word output bus and status flags of the instruction encoder.
// The encoder takes the slave side and the producer/consumer the master side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [9:0]  out_addr;
    logic        done;
    logic        err;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_word, out_addr, done, err
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_word, out_addr, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS instruction field sets into words, tags each with a sequential word address
// and queues them in a 2-entry FIFO whose head register drives the output bus.
module instr_encoder (
    input  logic               clk,
    input  logic               rst_n,
    instr_encoder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] KIND_HLT = 4'd7;

    function automatic logic is_legal(input logic [3:0] kind);
        return (kind < 4'd8);
    endfunction

    function automatic logic [31:0] encode_word(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (kind)
            4'd0:    word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd2:    word = {6'h08, rs, rt, imm};
            4'd3:    word = {6'h02, target};
            4'd4:    word = {6'h04, rs, rt, imm};
            4'd5:    word = {6'h23, rs, rt, imm};
            4'd6:    word = {6'h2B, rs, rt, imm};
            4'd7:    word = {6'h3F, 26'd0};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [9:0]  addr_r;
    logic        err_r;
    logic        done_r;
    logic        in_ready_r;
    logic        in_ready_nx_s;

    logic [31:0] head_word_r;
    logic [9:0]  head_addr_r;
    logic        head_valid_r;
    logic [31:0] tail_word_r;
    logic [9:0]  tail_addr_r;
    logic        tail_valid_r;

    logic        accept_s;
    logic        legal_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] word_s;
    logic [1:0]  cnt_s;
    logic [1:0]  cnt_nx_s;

    assign accept_s = bus.in_valid & in_ready_r;
    assign legal_s  = is_legal(bus.in_kind);
    assign push_s   = accept_s & legal_s;
    assign pop_s    = head_valid_r & bus.out_ready;
    assign word_s   = encode_word(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                                  bus.in_imm, bus.in_target);
    assign cnt_s    = {1'b0, head_valid_r} + {1'b0, tail_valid_r};
    assign cnt_nx_s = cnt_s + {1'b0, push_s} - {1'b0, pop_s};

    // Next-state logic; in_ready is precomputed from the post-edge state so it stays registered.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (push_s && (bus.in_kind == KIND_HLT)) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (cnt_s == 2'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nx_s = ST_DONE;
            default:  state_nx_s = ST_RUN;
        endcase
        in_ready_nx_s = (state_nx_s == ST_RUN) && (cnt_nx_s < 2'd2);
    end

    // Control state, address counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            addr_r     <= 10'd0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            err_r      <= err_r | (accept_s & ~legal_s);
            done_r     <= (state_nx_s == ST_DONE);
            in_ready_r <= in_ready_nx_s;
            if (push_s) begin
                addr_r <= addr_r + 10'd1;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Two-entry FIFO: the head register feeds the outputs, the tail only buffers behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_word_r  <= 32'h0000_0000;
            head_addr_r  <= 10'd0;
            head_valid_r <= 1'b0;
            tail_word_r  <= 32'h0000_0000;
            tail_addr_r  <= 10'd0;
            tail_valid_r <= 1'b0;
        end else if (pop_s) begin
            if (tail_valid_r) begin
                head_word_r  <= tail_word_r;
                head_addr_r  <= tail_addr_r;
                head_valid_r <= 1'b1;
                if (push_s) begin
                    tail_word_r  <= word_s;
                    tail_addr_r  <= addr_r;
                    tail_valid_r <= 1'b1;
                end else begin
                    tail_valid_r <= 1'b0;
                end
            end else if (push_s) begin
                head_word_r  <= word_s;
                head_addr_r  <= addr_r;
                head_valid_r <= 1'b1;
            end else begin
                head_valid_r <= 1'b0;
            end
        end else if (push_s) begin
            if (head_valid_r) begin
                tail_word_r  <= word_s;
                tail_addr_r  <= addr_r;
                tail_valid_r <= 1'b1;
            end else begin
                head_word_r  <= word_s;
                head_addr_r  <= addr_r;
                head_valid_r <= 1'b1;
            end
        end else begin
            head_valid_r <= head_valid_r;
            tail_valid_r <= tail_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = head_valid_r;
    assign bus.out_word  = head_word_r;
    assign bus.out_addr  = head_addr_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the encoder.
module tb_instr_encoder;

    typedef struct packed {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

    typedef struct packed {
        logic        irdy;
        logic        ovalid;
        logic [31:0] word;
        logic [9:0]  addr;
        logic        done;
        logic        err;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if bus ();
    instr_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int compared = 0;
    int mismatched = 0;

    logic [41:0] exp_q[$];
    int          model_addr;
    bit          model_err;
    bit          model_halted;

    // Reference encoding: opcode/funct table straight from the instruction formats.
    function automatic logic [31:0] ref_encode(input fields_t f);
        logic [5:0] opc;
        case (f.kind)
            4'd0: return {6'd0, f.rs, f.rt, f.rd, 5'd0, 6'd32};
            4'd1: return {6'd0, f.rs, f.rt, f.rd, 5'd0, 6'd42};
            4'd3: return {6'd2, f.target};
            4'd7: return 32'hFC00_0000;
            default: begin
                opc = (f.kind == 4'd2) ? 6'd8 : (f.kind == 4'd4) ? 6'd4 :
                      (f.kind == 4'd5) ? 6'd35 : 6'd43;
                return {opc, f.rs, f.rt, f.imm};
            end
        endcase
    endfunction

    function automatic fields_t rand_fields(input logic [3:0] k);
        fields_t f;
        f.kind   = k;
        f.rs     = 5'($urandom);
        f.rt     = 5'($urandom);
        f.rd     = 5'($urandom);
        f.imm    = 16'($urandom);
        f.target = 26'($urandom);
        return f;
    endfunction

    function automatic fields_t mk(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [15:0] imm,
                                   input logic [25:0] tg);
        fields_t f;
        f.kind = k; f.rs = rs; f.rt = rt; f.rd = rd; f.imm = imm; f.target = tg;
        return f;
    endfunction

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_addr = 0;
        model_err = 1'b0;
        model_halted = 1'b0;
    endtask

    // One clock: drive at the falling edge, sample outputs there, then let the rising edge act.
    task automatic cycle(input logic v, input fields_t f, input logic ordy, output sample_t s);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_kind   = f.kind;
        bus.in_rs     = f.rs;
        bus.in_rt     = f.rt;
        bus.in_rd     = f.rd;
        bus.in_imm    = f.imm;
        bus.in_target = f.target;
        bus.out_ready = ordy;
        s.irdy   = bus.in_ready;
        s.ovalid = bus.out_valid;
        s.word   = bus.out_word;
        s.addr   = bus.out_addr;
        s.done   = bus.done;
        s.err    = bus.err;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Reference model update: pop precedes push so a same-cycle push lands behind the head.
    task automatic model_step(input logic acc, input fields_t f, input logic pop,
                              output logic [41:0] exp_pop);
        exp_pop = 42'h0;
        if (pop && exp_q.size() != 0) exp_pop = exp_q.pop_front();
        if (acc) begin
            if (f.kind < 4'd8) begin
                exp_q.push_back({10'(model_addr), ref_encode(f)});
                model_addr = (model_addr + 1) % 1024;
                if (f.kind == 4'd7) model_halted = 1'b1;
            end else begin
                model_err = 1'b1;
            end
        end
    endtask

    function automatic logic exp_irdy();
        return !model_halted && (exp_q.size() < 2);
    endfunction

    task automatic test_reset();
        sample_t s;
        logic [41:0] e;
        fields_t f;
        apply_reset();
        f = rand_fields(4'd12);
        cycle(1'b1, f, 1'b0, s);
        f = rand_fields(4'd0);
        cycle(1'b1, f, 1'b0, s);
        cycle(1'b1, rand_fields(4'd5), 1'b0, s);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({bus.in_ready, bus.out_valid, bus.out_word, bus.out_addr, bus.done, bus.err} !== 46'h0) begin
            mismatched++;
            $display("FAIL reset_state: got rdy=%b v=%b w=%h a=%0d done=%b err=%b expected all zero",
                     bus.in_ready, bus.out_valid, bus.out_word, bus.out_addr, bus.done, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_rdy: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_first_edge: got rdy=%b v=%b expected rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
        exp_q.delete();
        model_addr = 0; model_err = 1'b0; model_halted = 1'b0;
        f = rand_fields(4'd6);
        cycle(1'b1, f, 1'b1, s);
        model_step(s.irdy, f, 1'b0, e);
        cycle(1'b0, f, 1'b1, s);
        model_step(1'b0, f, s.ovalid, e);
        compared++;
        if (s.ovalid !== 1'b1 || {s.addr, s.word} !== e || s.addr !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_restart: got v=%b a=%0d w=%h expected v=1 %h", s.ovalid, s.addr, s.word, e);
        end
    endtask

    task automatic test_add();
        sample_t s;
        apply_reset();
        cycle(1'b1, mk(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FF_FFFF), 1'b1, s);
        compared++;
        if (s.irdy !== 1'b1) begin
            mismatched++;
            $display("FAIL add_accept: got in_ready %b expected 1", s.irdy);
        end
        cycle(1'b0, rand_fields(4'd0), 1'b1, s);
        compared++;
        if (s.ovalid !== 1'b1 || s.word !== 32'h0022_1820 || s.addr !== 10'd0) begin
            mismatched++;
            $display("FAIL add_word: got v=%b w=%h a=%0d expected v=1 w=00221820 a=0", s.ovalid, s.word, s.addr);
        end
    endtask

    task automatic test_addi_lw();
        sample_t s;
        apply_reset();
        cycle(1'b1, mk(4'd2, 5'd0, 5'd5, 5'd9, 16'hFFFF, 26'd77), 1'b0, s);
        cycle(1'b1, mk(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0), 1'b0, s);
        compared++;
        if (s.irdy !== 1'b1) begin
            mismatched++;
            $display("FAIL lw_accept: got in_ready %b expected 1", s.irdy);
        end
        cycle(1'b0, rand_fields(4'd0), 1'b1, s);
        compared++;
        if (s.word !== 32'h2005_FFFF || s.addr !== 10'd0) begin
            mismatched++;
            $display("FAIL addi_word: got w=%h a=%0d expected 2005ffff a=0", s.word, s.addr);
        end
        cycle(1'b0, rand_fields(4'd0), 1'b1, s);
        compared++;
        if (s.ovalid !== 1'b1 || s.word !== 32'h8FA8_0004 || s.addr !== 10'd1) begin
            mismatched++;
            $display("FAIL lw_word: got v=%b w=%h a=%0d expected 8fa80004 a=1", s.ovalid, s.word, s.addr);
        end
    endtask

    task automatic test_back_to_back();
        sample_t s;
        fields_t w[3];
        logic [41:0] e;
        int idx = 0;
        int pops = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) w[i] = rand_fields(4'($urandom_range(0, 6)));
        for (int c = 0; c < 12; c++) begin
            logic o = (c >= 6);
            cycle(idx < 3, w[idx < 3 ? idx : 2], o, s);
            compared++;
            if (s.irdy !== exp_irdy()) begin
                mismatched++;
                $display("FAIL bp_in_ready: cycle %0d got %b expected %b", c, s.irdy, exp_irdy());
            end
            if (c >= 1 && c <= 6) begin
                compared++;
                if (s.ovalid !== 1'b1 || s.word !== ref_encode(w[0]) || s.addr !== 10'd0) begin
                    mismatched++;
                    $display("FAIL bp_stable: cycle %0d got v=%b w=%h a=%0d expected %h a=0",
                             c, s.ovalid, s.word, s.addr, ref_encode(w[0]));
                end
            end
            model_step((idx < 3) && s.irdy, w[idx < 3 ? idx : 2], s.ovalid & o, e);
            if (s.ovalid & o) begin
                pops++;
                compared++;
                if ({s.addr, s.word} !== e) begin
                    mismatched++;
                    $display("FAIL bp_order: got a=%0d w=%h expected %h", s.addr, s.word, e);
                end
            end
            if ((idx < 3) && s.irdy) idx++;
            if (c == 5) begin
                compared++;
                if (idx !== 2) begin
                    mismatched++;
                    $display("FAIL bp_accepted: got %0d expected 2", idx);
                end
            end
        end
        compared++;
        if (pops !== 3) begin
            mismatched++;
            $display("FAIL bp_pops: got %0d expected 3", pops);
        end
    endtask

    task automatic test_illegal();
        sample_t s;
        logic [41:0] e;
        fields_t seq[3];
        logic [31:0] got_w[$];
        logic [9:0]  got_a[$];
        apply_reset();
        seq[0] = mk(4'd3, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h100);
        seq[1] = rand_fields(4'd9);
        seq[2] = rand_fields(4'd4);
        for (int c = 0; c < 6; c++) begin
            cycle(c < 3, seq[c < 3 ? c : 2], 1'b1, s);
            if (c == 1) begin
                compared++;
                if (s.err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL ill_err_early: got %b expected 0", s.err);
                end
            end
            if (c == 2) begin
                compared++;
                if (s.err !== 1'b1) begin
                    mismatched++;
                    $display("FAIL ill_err_set: got %b expected 1", s.err);
                end
            end
            model_step((c < 3) && s.irdy, seq[c < 3 ? c : 2], s.ovalid, e);
            if (s.ovalid) begin
                got_w.push_back(s.word);
                got_a.push_back(s.addr);
            end
        end
        compared++;
        if (got_w.size() != 2 || got_w[0] !== 32'h0800_0100 || got_a[0] !== 10'd0 ||
            got_w[1] !== ref_encode(seq[2]) || got_a[1] !== 10'd1) begin
            mismatched++;
            $display("FAIL ill_sequence: got %0d words first=%h@%0d expected 08000100@0 then %h@1",
                     got_w.size(), got_w.size() > 0 ? got_w[0] : 32'h0,
                     got_a.size() > 0 ? got_a[0] : 10'h0, ref_encode(seq[2]));
        end
    endtask

    task automatic test_wrap();
        sample_t s;
        logic [41:0] e;
        fields_t f;
        int sent = 0;
        int pops = 0;
        logic [9:0] last_a = 10'h3FF;
        apply_reset();
        for (int c = 0; c < 1100 && pops < 1025; c++) begin
            f = rand_fields(4'($urandom_range(0, 6)));
            cycle(sent < 1025, f, 1'b1, s);
            model_step((sent < 1025) && s.irdy, f, s.ovalid, e);
            if ((sent < 1025) && s.irdy) sent++;
            if (s.ovalid) begin
                pops++;
                last_a = s.addr;
                compared++;
                if ({s.addr, s.word} !== e) begin
                    mismatched++;
                    $display("FAIL wrap_word: pop %0d got a=%0d w=%h expected %h", pops, s.addr, s.word, e);
                end
            end
        end
        compared++;
        if (pops !== 1025 || last_a !== 10'd0) begin
            mismatched++;
            $display("FAIL wrap_last: got %0d pops last addr %0d expected 1025 pops addr 0", pops, last_a);
        end
    endtask

    task automatic test_random();
        sample_t s;
        logic [41:0] e;
        fields_t f;
        logic v, o;
        logic [3:0] k;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            k = 4'($urandom_range(0, 15));
            if (k == 4'd7) k = 4'd1;
            f = rand_fields(k);
            v = 1'($urandom_range(0, 1));
            o = ($urandom_range(0, 3) != 0);
            cycle(v, f, o, s);
            compared++;
            if (s.irdy !== exp_irdy() || s.ovalid !== (exp_q.size() != 0) || s.err !== model_err) begin
                mismatched++;
                $display("FAIL rnd_status: cycle %0d got rdy=%b v=%b err=%b expected rdy=%b v=%b err=%b",
                         i, s.irdy, s.ovalid, s.err, exp_irdy(), exp_q.size() != 0, model_err);
            end
            model_step(v & s.irdy, f, s.ovalid & o, e);
            if (s.ovalid & o) begin
                compared++;
                if ({s.addr, s.word} !== e) begin
                    mismatched++;
                    $display("FAIL rnd_word: cycle %0d got a=%0d w=%h expected %h", i, s.addr, s.word, e);
                end
            end
        end
    endtask

    task automatic test_halt();
        sample_t s;
        logic [41:0] e;
        fields_t a;
        int pops = 0;
        logic [31:0] last_w = 32'h0;
        bit seen_done = 1'b0;
        apply_reset();
        a = rand_fields(4'($urandom_range(0, 6)));
        cycle(1'b1, a, 1'b0, s);
        model_step(s.irdy, a, 1'b0, e);
        cycle(1'b1, rand_fields(4'd7), 1'b0, s);
        model_step(s.irdy, mk(4'd7, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0), 1'b0, e);
        for (int c = 0; c < 20; c++) begin
            logic o = c[0];
            cycle(1'b1, rand_fields(4'd0), o, s);
            compared++;
            if (s.irdy !== 1'b0 || (s.done && exp_q.size() != 0)) begin
                mismatched++;
                $display("FAIL halt_status: cycle %0d got rdy=%b done=%b with %0d pending expected rdy=0",
                         c, s.irdy, s.done, exp_q.size());
            end
            if (s.done) seen_done = 1'b1;
            model_step(1'b0, a, s.ovalid & o, e);
            if (s.ovalid & o) begin
                pops++;
                last_w = s.word;
                compared++;
                if ({s.addr, s.word} !== e) begin
                    mismatched++;
                    $display("FAIL halt_order: got a=%0d w=%h expected %h", s.addr, s.word, e);
                end
            end
        end
        compared++;
        if (!seen_done || s.done !== 1'b1 || pops != 2 || last_w !== 32'hFC00_0000) begin
            mismatched++;
            $display("FAIL halt_done: got done=%b pops=%0d last=%h expected done=1 pops=2 last=fc000000",
                     s.done, pops, last_w);
        end
        apply_reset();
        compared++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL halt_rst: got done=%b rdy=%b expected done=0 rdy=1", bus.done, bus.in_ready);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_kind = 4'd0;
        bus.in_rs = 5'd0;
        bus.in_rt = 5'd0;
        bus.in_rd = 5'd0;
        bus.in_imm = 16'd0;
        bus.in_target = 26'd0;
        test_reset();
        test_add();
        test_addi_lw();
        test_back_to_back();
        test_illegal();
        test_wrap();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
